// File: rtl/pr_avmm_freeze_bridge.sv
// rtl/pr_avmm_freeze_bridge.sv - Avalon-MM freeze bridge between a PR region master and the NoC
// Registers region commands toward the NoC, forwards read data, and isolates the region on freeze.
module pr_avmm_freeze_bridge #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 32,
  parameter int MAX_PEND      = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_req,
  output logic              freeze_ack,
  output logic              drain_timeout,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic              s_read,
  input  logic              s_write,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid
);

  localparam int PW = $clog2(MAX_PEND) + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} state_t;

  state_t            state, state_nxt;
  logic              cmd_valid, cmd_is_read;
  logic [PW-1:0]     pend_cnt, stale_cnt;
  logic [TW-1:0]     timer;
  logic              rdv_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept, rsp_drop, rsp_fwd, pend_inc, pend_dec;
  logic              drained, timed_out, force_drop;

  assign s_waitrequest = (state != RUN) || (cmd_valid && m_waitrequest) ||
                         (pend_cnt == PW'(MAX_PEND)) || (stale_cnt != '0);
  assign accept    = (s_read || s_write) && !s_waitrequest;
  // Responses owed to reads abandoned by a timed-out drain are swallowed here.
  assign rsp_drop  = m_readdatavalid && (stale_cnt != '0);
  assign rsp_fwd   = m_readdatavalid && !rsp_drop;
  assign pend_inc  = accept && s_read;
  assign pend_dec  = rsp_fwd && (pend_cnt != '0);
  assign drained   = !cmd_valid && (pend_cnt == '0);
  assign timed_out = (timer == TW'(DRAIN_TIMEOUT - 1));
  assign force_drop = (state == DRAIN) && freeze_req && !drained && timed_out;

  always_comb begin
    state_nxt       = state;
    freeze_ack      = 1'b0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
    case (state)
      RUN: begin
        if (freeze_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!freeze_req)             state_nxt = RUN;
        else if (drained || timed_out) state_nxt = FROZEN;
      end
      FROZEN: begin
        freeze_ack = 1'b1;
        if (!freeze_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (state != FROZEN) begin
      m_read          = cmd_valid && cmd_is_read;
      m_write         = cmd_valid && !cmd_is_read;
      s_readdatavalid = rdv_q;
      s_readdata      = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state == DRAIN) ? timer + TW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      cmd_is_read <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
    end else if (accept) begin
      cmd_valid   <= 1'b1;
      cmd_is_read <= s_read;
      m_address   <= s_address;
      m_writedata <= s_writedata;
    end else if (force_drop || !m_waitrequest) begin
      cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt  <= '0;
      stale_cnt <= '0;
    end else if (force_drop) begin
      // Reads still owed at the timeout become stale; a response landing now is already accounted.
      pend_cnt  <= '0;
      stale_cnt <= pend_cnt - PW'(pend_dec);
    end else begin
      if (pend_inc && !pend_dec)      pend_cnt <= pend_cnt + PW'(1);
      else if (pend_dec && !pend_inc) pend_cnt <= pend_cnt - PW'(1);
      if (rsp_drop) stale_cnt <= stale_cnt - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == FROZEN) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdv_q   <= rsp_fwd;
      rdata_q <= m_readdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             drain_timeout <= 1'b0;
    else if (force_drop) drain_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_pr_avmm_freeze_bridge.sv
// tb/tb_pr_avmm_freeze_bridge.sv - self-checking bench for pr_avmm_freeze_bridge
// A transaction-level model predicts every output each cycle; directed tests add literal checks.
module tb_pr_avmm_freeze_bridge;

  localparam int MAXP = 8;
  localparam int TOUT = 1024;

  logic        clk = 1'b0, rst = 1'b1, freeze_req = 1'b0;
  logic        s_read = 1'b0, s_write = 1'b0, m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [19:0] s_address = '0;
  logic [31:0] s_writedata = '0, m_readdata = '0;
  logic        freeze_ack, drain_timeout, s_waitrequest, s_readdatavalid, m_read, m_write;
  logic [31:0] s_readdata, m_writedata;
  logic [19:0] m_address;

  int tests = 0;
  int fails = 0;

  pr_avmm_freeze_bridge #(.ADDR_W(20), .DATA_W(32), .MAX_PEND(MAXP), .DRAIN_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .freeze_req(freeze_req), .freeze_ack(freeze_ack),
    .drain_timeout(drain_timeout), .s_address(s_address), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .m_address(m_address),
    .m_writedata(m_writedata), .m_read(m_read), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0=running, 1=draining, 2=frozen
  int          mode = 0;
  bit          have_cmd = 0, cmd_rd = 0, to_flag = 0, rsp_v = 0;
  logic [19:0] cmd_a = '0;
  logic [31:0] cmd_d = '0, rsp_d = '0;
  int          outstanding = 0, stale = 0, drain_cycles = 0;

  function automatic bit exp_wait();
    return (mode != 0) || (have_cmd && m_waitrequest) || (outstanding >= MAXP) || (stale > 0);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mode = 0; have_cmd = 0; cmd_rd = 0; to_flag = 0; rsp_v = 0;
      cmd_a = '0; cmd_d = '0; rsp_d = '0; outstanding = 0; stale = 0; drain_cycles = 0;
    end else begin
      bit acc, drop, fwd, had_cmd;
      int o_new;
      acc  = (s_read || s_write) && !exp_wait();
      drop = m_readdatavalid && (stale > 0);
      fwd  = m_readdatavalid && !drop;
      o_new = outstanding + ((acc && s_read) ? 1 : 0) - ((fwd && outstanding > 0) ? 1 : 0);
      if (drop) stale = stale - 1;
      if (mode == 2) begin rsp_v = 0; rsp_d = '0; end
      else begin rsp_v = fwd; rsp_d = m_readdata; end
      had_cmd = have_cmd;
      if (acc) begin
        have_cmd = 1; cmd_rd = s_read; cmd_a = s_address; cmd_d = s_writedata;
      end else if (!m_waitrequest) have_cmd = 0;
      case (mode)
        0: if (freeze_req) begin mode = 1; drain_cycles = 0; end
        1: begin
          if (!freeze_req) mode = 0;
          else if (!had_cmd && outstanding == 0) mode = 2;
          else if (drain_cycles == TOUT - 1) begin
            mode = 2; to_flag = 1; stale = o_new; o_new = 0; have_cmd = 0;
          end else drain_cycles = drain_cycles + 1;
        end
        default: if (!freeze_req) mode = 0;
      endcase
      outstanding = o_new;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_s_waitrequest", 32'(s_waitrequest), 32'(exp_wait()));
    chk("cmp_m_read", 32'(m_read), 32'(have_cmd && cmd_rd && mode != 2));
    chk("cmp_m_write", 32'(m_write), 32'(have_cmd && !cmd_rd && mode != 2));
    chk("cmp_m_address", 32'(m_address), 32'(cmd_a));
    chk("cmp_m_writedata", m_writedata, cmd_d);
    chk("cmp_s_readdatavalid", 32'(s_readdatavalid), 32'(rsp_v && mode != 2));
    chk("cmp_s_readdata", s_readdata, (mode == 2) ? 32'h0 : rsp_d);
    chk("cmp_freeze_ack", 32'(freeze_ack), 32'(mode == 2));
    chk("cmp_drain_timeout", 32'(drain_timeout), 32'(to_flag));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, seen;
    bit ack_seen;
    logic [31:0] last;
    repeat (2) tick();
    chk("rst_waitrequest", 32'(s_waitrequest), 32'h0);
    chk("rst_freeze_ack", 32'(freeze_ack), 32'h0);
    chk("rst_m_read", 32'(m_read), 32'h0);
    rst = 1'b0;
    tick();

    // single read, response three cycles after the command
    s_read = 1'b1; s_address = 20'h00010;
    tick();
    s_read = 1'b0;
    chk("t1_m_read", 32'(m_read), 32'h1);
    chk("t1_m_address", 32'(m_address), 32'h00010);
    repeat (3) tick();
    m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
    tick();
    m_readdatavalid = 1'b0; m_readdata = '0;
    chk("t1_rdv", 32'(s_readdatavalid), 32'h1);
    chk("t1_rdata", s_readdata, 32'hDEADBEEF);
    tick();
    chk("t1_rdv_low", 32'(s_readdatavalid), 32'h0);

    // back-to-back writes, then fill the read window
    s_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_address = 20'(i * 4); s_writedata = 32'hA000_0000 + 32'(i);
      tick();
      chk("t2_m_write", 32'(m_write), 32'h1);
      chk("t2_m_writedata", m_writedata, 32'hA000_0000 + 32'(i));
    end
    s_write = 1'b0;
    tick();
    chk("t2_m_write_low", 32'(m_write), 32'h0);
    for (int i = 0; i < 9; i++) begin
      s_read = 1'b1; s_address = 20'h00100 + 20'(i);
      chk("t2_window_wait", 32'(s_waitrequest), (i == 8) ? 32'h1 : 32'h0);
      tick();
    end
    s_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'h0000_5500 + 32'(i);
      tick();
    end
    m_readdatavalid = 1'b0;
    tick();
    chk("t2_window_free", 32'(s_waitrequest), 32'h0);

    // clean freeze with two reads outstanding
    s_read = 1'b1; s_address = 20'h00200;
    tick();
    s_address = 20'h00204;
    tick();
    s_read = 1'b0; freeze_req = 1'b1;
    tick();
    chk("t3_wait_drain", 32'(s_waitrequest), 32'h1);
    chk("t3_no_ack", 32'(freeze_ack), 32'h0);
    tick();
    m_readdatavalid = 1'b1; m_readdata = 32'h1111_1111;
    tick();
    m_readdata = 32'h2222_2222;
    tick();
    m_readdatavalid = 1'b0;
    chk("t3_second_rdv", 32'(s_readdatavalid), 32'h1);
    chk("t3_second_data", s_readdata, 32'h2222_2222);
    chk("t3_ack_not_yet", 32'(freeze_ack), 32'h0);
    tick();
    chk("t3_ack", 32'(freeze_ack), 32'h1);
    chk("t3_no_timeout", 32'(drain_timeout), 32'h0);
    freeze_req = 1'b0;
    tick();
    chk("t3_unfreeze_ack", 32'(freeze_ack), 32'h0);
    chk("t3_unfreeze_wait", 32'(s_waitrequest), 32'h0);

    // drain timeout with three reads never answered
    s_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_address = 20'h00300 + 20'(i);
      tick();
    end
    s_read = 1'b0; freeze_req = 1'b1;
    n = 0;
    while (!freeze_ack && n < 2000) begin
      tick();
      n++;
    end
    chk("t4_cycles_to_frozen", 32'(n), 32'd1025);
    chk("t4_drain_timeout", 32'(drain_timeout), 32'h1);
    freeze_req = 1'b0;
    tick();
    chk("t4_stale_wait", 32'(s_waitrequest), 32'h1);
    seen = 0; last = '0;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'hC000_0000 + 32'(i);
      tick();
      if (s_readdatavalid) begin seen++; last = s_readdata; end
    end
    m_readdatavalid = 1'b0;
    chk("t4_forwarded_count", 32'(seen), 32'd1);
    chk("t4_forwarded_data", last, 32'hC000_0003);
    chk("t4_wait_released", 32'(s_waitrequest), 32'h0);
    chk("t4_timeout_sticky", 32'(drain_timeout), 32'h1);

    // freeze abort with one read pending
    s_read = 1'b1; s_address = 20'h00400;
    tick();
    s_read = 1'b0; freeze_req = 1'b1; ack_seen = 0;
    repeat (5) begin
      tick();
      ack_seen = ack_seen | freeze_ack;
    end
    freeze_req = 1'b0;
    tick();
    chk("t5_back_to_run", 32'(s_waitrequest), 32'h0);
    m_readdatavalid = 1'b1; m_readdata = 32'hABCD_1234;
    tick();
    m_readdatavalid = 1'b0;
    chk("t5_rdv", 32'(s_readdatavalid), 32'h1);
    chk("t5_rdata", s_readdata, 32'hABCD_1234);
    chk("t5_ack_never", 32'(ack_seen), 32'h0);

    // asynchronous reset while a read is stalled by the NoC
    m_waitrequest = 1'b1; s_read = 1'b1; s_address = 20'h00007;
    tick();
    s_read = 1'b0;
    chk("t6_m_read_stalled", 32'(m_read), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_m_read", 32'(m_read), 32'h0);
    chk("t6_rst_m_address", 32'(m_address), 32'h0);
    chk("t6_rst_wait", 32'(s_waitrequest), 32'h0);
    chk("t6_rst_timeout", 32'(drain_timeout), 32'h0);
    chk("t6_rst_rdv", 32'(s_readdatavalid), 32'h0);
    repeat (2) tick();
    rst = 1'b0; m_waitrequest = 1'b0;
    tick();
    chk("t6_after_rst_wait", 32'(s_waitrequest), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pr_avmm_freeze_bridge.md
# pr_avmm_freeze_bridge

Freeze bridge between a PR user-logic region's Avalon-MM master (20-bit address, 32-bit data) and the static NoC slave port. It registers the region's commands toward the NoC and returns read data to the region. On a freeze request from the PR controller, it stops new commands, drains in-flight traffic and isolates the region. The PR region can then be reconfigured without corrupting NoC transactions.

## Interface
Parameters:
- ADDR_W, 20, address width
- DATA_W, 32, data width
- MAX_PEND, 8, maximum outstanding reads (power of two, ≥2)
- DRAIN_TIMEOUT, 1024, DRAIN cycles before a forced freeze

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high; clears all state
- freeze_req  in  1  from PR controller, level
- freeze_ack  out  1  region isolated, no traffic outstanding
- drain_timeout  out  1  sticky; DRAIN ended by timeout; cleared only by rst
- s_address / s_writedata  in  ADDR_W / DATA_W  from region master
- s_read / s_write  in  1  from region master
- s_waitrequest  out  1  to region
- s_readdata  out  DATA_W  to region
- s_readdatavalid  out  1  to region
- m_address / m_writedata  out  ADDR_W / DATA_W  to NoC
- m_read / m_write  out  1  to NoC
- m_waitrequest  in  1  from NoC
- m_readdata  in  DATA_W  from NoC
- m_readdatavalid  in  1  from NoC

## Operation
- Command register (cmd_valid):
  - Slave accept condition: (s_read|s_write) && !s_waitrequest.
  - On accept, load address, data and type.
  - Clear cmd_valid when !m_waitrequest and no new accept in the same cycle.
  - m_read = cmd_valid && type==read; m_write likewise.
  - s_read and s_write both high is illegal: read takes priority.
- s_waitrequest = (state!=RUN) || (cmd_valid && m_waitrequest) || (pend_cnt==MAX_PEND).
- pend_cnt (width log2(MAX_PEND)+1):
  - +1 on an accepted read.
  - -1 on m_readdatavalid (when not dropped as stale).
  - Simultaneous +1/-1 leaves it unchanged.
  - Never exceeds MAX_PEND.
- Read return: s_readdata/s_readdatavalid are registered copies of m_readdata/m_readdatavalid in RUN and DRAIN. In FROZEN they are forced to 0.
- States:
  - RUN:
    - freeze_req=1 → DRAIN.
  - DRAIN:
    - No new accepts.
    - The command register still issues to the NoC.
    - Responses are still forwarded.
    - timer counts up from 0.
    - Exits:
      - freeze_req=0 → RUN.
      - !cmd_valid && pend_cnt==0 → FROZEN.
      - timer==DRAIN_TIMEOUT-1 → FROZEN: set drain_timeout, stale_cnt←pend_cnt, pend_cnt←0, cmd_valid←0 (command dropped).
    - The normal exit has priority over the timeout in the same cycle.
  - FROZEN:
    - freeze_ack=1.
    - m_read=m_write=0.
    - s_waitrequest=1, s_readdatavalid=0, s_readdata=0.
    - freeze_req=0 → RUN.
- stale_cnt:
  - Any m_readdatavalid while stale_cnt>0 (any state) decrements stale_cnt and is not forwarded.
  - A dropped response does not affect pend_cnt.
  - pend_cnt does not increment while stale_cnt>0; s_waitrequest is held high.
  - This prevents misattribution after unfreeze.

## Timing
- Reset values:
  - state=RUN, cmd_valid=0, pend_cnt=0, stale_cnt=0, timer=0.
  - freeze_ack=0, drain_timeout=0.
  - m_read=m_write=0, m_address=0, m_writedata=0.
  - s_readdatavalid=0, s_readdata=0.
  - s_waitrequest=0 immediately after reset.
- Command latency: slave accept in cycle N → m_read/m_write high in cycle N+1. Throughput is 1 command/cycle while !m_waitrequest.
- m_* are held stable while m_waitrequest=1.
- Read data latency: m_readdatavalid in cycle N → s_readdatavalid in N+1.
- freeze_req rising in cycle N: state=DRAIN in N+1, so s_waitrequest=1 from N+1. An accept in cycle N is still honoured.
- freeze_ack rises in the cycle after the drain condition is met. It falls in the cycle after freeze_req falls, together with s_waitrequest.
- A response in the last DRAIN cycle is forwarded in the first FROZEN cycle's register update, then masked. The region must tolerate its loss; freeze is asserted only with the region idle.
- An asynchronous rst mid-transaction drops all state. NoC responses for reads issued before reset are not tracked.

## Test plan
- Single read: read addr 0x00010, NoC returns 0xDEADBEEF 3 cycles later → m_read in cycle+1, s_readdatavalid with 0xDEADBEEF one cycle after m_readdatavalid; pend_cnt returns to 0.
- Back-to-back writes: 4 writes addr 0x0,0x4,0x8,0xC, m_waitrequest=0 → m_write high 4 consecutive cycles with matching data. Then 8 reads with no responses → s_waitrequest=1 on the 9th read.
- Clean freeze: 2 reads outstanding, freeze_req=1 → s_waitrequest=1 next cycle; both responses forwarded; freeze_ack=1 one cycle after the second response; drain_timeout=0.
- Timeout: 3 reads outstanding, never answered, freeze_req=1 → FROZEN after 1024 DRAIN cycles, drain_timeout=1, stale_cnt=3. After unfreeze, the first 3 m_readdatavalid pulses are not forwarded and the 4th is.
- Freeze abort and reset: freeze_req pulsed 5 cycles with 1 read pending → back to RUN, response forwarded, freeze_ack never high. rst asserted with cmd_valid=1 and m_waitrequest=1 → m_read=0 immediately, all outputs at reset values.
